approx_adder_pipe: RTL and testbench
====================================

APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width in bits.
REQ-002 Parameter APPROX_BITS, default 2, SHALL set the number of approximated LSBs K, legal range 0..WIDTH.
REQ-003 Parameter ET, default 4, SHALL set the error threshold; an error strictly greater than ET is a violation.
REQ-004 Parameter COUNT_W, default 16, SHALL set the width of the violation counter.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 in_valid  in  1  SHALL mean the operand pair is offered.
REQ-008 in_ready  out  1  SHALL mean the block accepts the pair this cycle.
REQ-009 in_a, in_b  in  WIDTH each  SHALL be the unsigned operands.
REQ-010 in_mode  in  2  SHALL select the mode: 0 exact, 1 truncate, 2 lower-part OR (LOA), 3 lower-ones.
REQ-011 out_valid  out  1 / out_ready  in  1  SHALL form the result handshake.
REQ-012 out_sum, out_exact, out_err  out  WIDTH+1 each  SHALL carry the approximate sum, the exact sum and |exact - approx|.
REQ-013 out_viol  out  1  SHALL be high when out_err > ET.
REQ-014 stat_clr  in  1 / viol_cnt  out  COUNT_W / max_err  out  WIDTH+1  SHALL clear the statistics, count violations and report the maximum error seen.

Function
REQ-015 Result width SHALL be WIDTH+1; arithmetic is unsigned, with no overflow loss.
REQ-016 Mode 0 SHALL produce approx = a + b.
REQ-017 Mode 1 SHALL force the low K bits to 0; upper = a[W-1:K] + b[W-1:K] with carry-in 0.
REQ-018 Mode 2 SHALL set low K bits = a|b; upper = a[W-1:K] + b[W-1:K] + (a[K-1] & b[K-1]); with K=0 it equals mode 0.
REQ-019 Mode 3 SHALL force the low K bits to 1; upper is as in mode 1.
REQ-020 in_mode SHALL be sampled at acceptance and travel with its data; mode changes between transfers SHALL NOT affect in-flight items.
REQ-021 Pipeline SHALL have 2 stages: S1 registers operands, mode, approx and exact sums; S2 registers err and viol. Latency from acceptance to out_valid SHALL be 2 cycles with no stall.
REQ-022 Transfer occurs when valid & ready are high on the same edge.
REQ-023 S2 SHALL load when S2 is empty or out_ready = 1; S1 SHALL advance when S2 loads; in_ready = !S1_valid | S1 advances.
REQ-024 Full throughput of 1 item per cycle SHALL be sustained while out_ready = 1.
REQ-025 While out_valid = 1 and out_ready = 0, all out_* SHALL hold stable.
REQ-026 viol_cnt SHALL increment once per output transfer with out_viol = 1, and saturate at 2^COUNT_W-1.
REQ-027 max_err SHALL update to out_err on each output transfer where out_err > max_err.
REQ-028 When stat_clr coincides with a transfer, clear SHALL win: viol_cnt = 0, max_err = 0, and the concurrent item is not counted.

Reset
REQ-029 rst SHALL immediately clear S1/S2 valid, out_valid, viol_cnt, max_err, out_sum, out_exact, out_err and out_viol to 0; in-flight data is discarded.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the mode enumeration (EXACT, TRUNC, LOA, ONES) and the mode width constant.
REQ-032 The combinational approximate-sum datapath SHALL be one sub-module, approx_sum_core (WIDTH, APPROX_BITS, mode -> sum), instantiated in S1.

Verification
REQ-033 Use WIDTH=4, K=2, ET=4. a=3, b=3, mode 1 -> out_sum 0, out_exact 6, out_err 6, out_viol 1, viol_cnt 1.
REQ-034 a=3, b=3, mode 2 -> out_sum 7, out_err 1, out_viol 0; mode 3 -> out_sum 3, out_err 3, out_viol 0; mode 0 -> out_sum 6, out_err 0.
REQ-035 Backpressure: in_valid=1 each cycle, out_ready=0 for 4 cycles -> exactly 2 items accepted, then in_ready=0; outputs stable; after out_ready=1 the items appear in order with no loss or duplication.
REQ-036 With COUNT_W=4, feed 20 violating items -> viol_cnt saturates at 15; then stat_clr on a violating transfer -> viol_cnt 0, max_err 0.
REQ-037 Assert rst while 2 items are in flight -> out_valid 0 asynchronously, no output transfer, viol_cnt 0; a new item after reset appears 2 cycles after acceptance.
REQ-038 Random 10k-item regression over all modes and K = 0..WIDTH with random out_ready SHALL match a reference model on all outputs.

Source files
------------

// File: rtl/approx_adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// approx_adder_pipe_pkg
// Shared definitions for the approximate adder pipeline: the adder mode
// encoding and its width.
// -----------------------------------------------------------------------------
package approx_adder_pipe_pkg;

    localparam int MODE_W = 2;

    // Adder modes: exact, truncated low part, lower-part OR, low part forced to ones
    typedef enum logic [MODE_W-1:0] {
        EXACT = 2'd0,
        TRUNC = 2'd1,
        LOA   = 2'd2,
        ONES  = 2'd3
    } mode_e;

endpackage : approx_adder_pipe_pkg

// File: rtl/approx_sum_core.sv
// -----------------------------------------------------------------------------
// approx_sum_core
// Combinational approximate adder. The low APPROX_BITS bits are produced by
// the selected approximation; the upper part is a normal carry-propagate sum.
// Ports:
//   a, b  in  WIDTH    unsigned operands
//   mode  in  MODE_W   EXACT / TRUNC / LOA / ONES
//   sum   out WIDTH+1  approximate sum (no overflow loss)
// -----------------------------------------------------------------------------
module approx_sum_core
    import approx_adder_pipe_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int APPROX_BITS = 2
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH:0]    sum
);

    // Mask selecting the approximated low bits of a WIDTH+1 result.
    localparam logic [WIDTH:0] LOW_MASK = (WIDTH+1)'((64'd1 << APPROX_BITS) - 64'd1);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] upper_a;
    logic [WIDTH:0] upper_b;
    logic [WIDTH:0] upper_plain;
    logic [WIDTH:0] upper_loa;
    logic           lsb_and;

    assign a_ext       = {1'b0, a};
    assign b_ext       = {1'b0, b};
    assign upper_a     = a_ext >> APPROX_BITS;
    assign upper_b     = b_ext >> APPROX_BITS;
    assign upper_plain = upper_a + upper_b;
    assign upper_loa   = upper_plain + {{WIDTH{1'b0}}, lsb_and};

    // LOA carries the AND of the top approximated bits into the upper part;
    // with no approximated bits there is nothing to carry.
    generate
        if (APPROX_BITS == 0) begin : g_no_lsb
            assign lsb_and = 1'b0;
        end else begin : g_lsb
            assign lsb_and = a[APPROX_BITS-1] & b[APPROX_BITS-1];
        end
    endgenerate

    // Mode select: assemble upper part and low approximated bits
    always_comb begin
        sum = a_ext + b_ext;
        case (mode_e'(mode))
            EXACT:   sum = a_ext + b_ext;
            TRUNC:   sum = upper_plain << APPROX_BITS;
            LOA:     sum = (upper_loa << APPROX_BITS) | ((a_ext | b_ext) & LOW_MASK);
            ONES:    sum = (upper_plain << APPROX_BITS) | LOW_MASK;
            default: sum = a_ext + b_ext;
        endcase
    end

endmodule : approx_sum_core

// File: rtl/approx_adder_pipe.sv
// -----------------------------------------------------------------------------
// approx_adder_pipe
// Two-stage valid/ready pipeline around an approximate adder. Stage 1 holds
// the mode plus approximate and exact sums; stage 2 holds the outputs along
// with the absolute error and the threshold-violation flag. Running
// statistics (violation count, maximum error) update on output transfers.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        operand handshake
//   in_a, in_b  (WIDTH)      unsigned operands
//   in_mode     (2)          EXACT / TRUNC / LOA / ONES, travels with data
//   out_valid/out_ready      result handshake
//   out_sum, out_exact, out_err (WIDTH+1)  approx sum, exact sum, |diff|
//   out_viol                 out_err > ET
//   stat_clr                 clear statistics (wins over a concurrent transfer)
//   viol_cnt (COUNT_W)       saturating count of violating output transfers
//   max_err  (WIDTH+1)       largest out_err transferred since clear
// -----------------------------------------------------------------------------
module approx_adder_pipe
    import approx_adder_pipe_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int APPROX_BITS = 2,
    parameter int ET          = 4,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [MODE_W-1:0]  in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic [WIDTH:0]     out_exact,
    output logic [WIDTH:0]     out_err,
    output logic               out_viol,
    input  logic               stat_clr,
    output logic [COUNT_W-1:0] viol_cnt,
    output logic [WIDTH:0]     max_err
);

    localparam logic [COUNT_W-1:0] CNT_MAX      = {COUNT_W{1'b1}};
    localparam logic [WIDTH:0]     ERR_ZERO     = {(WIDTH+1){1'b0}};
    // A threshold beyond the error range can never be exceeded.
    localparam logic               ET_REACHABLE = (ET < (1 << (WIDTH + 1)));
    localparam logic [WIDTH:0]     ET_VAL       = (WIDTH+1)'(ET);

    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x,
                                                 input logic [WIDTH:0] y);
        if (x >= y) begin
            return x - y;
        end else begin
            return y - x;
        end
    endfunction

    logic              s1_valid;
    logic [MODE_W-1:0] s1_mode;
    logic [WIDTH:0]    s1_sum;
    logic [WIDTH:0]    s1_exact;

    logic [WIDTH:0]    core_sum;
    logic [WIDTH:0]    core_exact;
    logic [WIDTH:0]    err_next;
    logic              viol_next;

    logic              s2_load;
    logic              accept;
    logic              out_xfer;

    assign s2_load    = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid | s2_load;
    assign accept     = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    assign core_exact = {1'b0, in_a} + {1'b0, in_b};

    approx_sum_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a    (in_a),
        .b    (in_b),
        .mode (in_mode),
        .sum  (core_sum)
    );

    // Stage-2 error and violation; exact mode is error-free by construction
    always_comb begin
        err_next  = ERR_ZERO;
        viol_next = 1'b0;
        if (s1_mode == EXACT) begin
            err_next = ERR_ZERO;
        end else begin
            err_next = abs_diff(s1_exact, s1_sum);
        end
        if (ET_REACHABLE && (err_next > ET_VAL)) begin
            viol_next = 1'b1;
        end else begin
            viol_next = 1'b0;
        end
    end

    // Stage 1: capture mode and both sums on acceptance; empty when it advances without new input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= {MODE_W{1'b0}};
            s1_sum   <= ERR_ZERO;
            s1_exact <= ERR_ZERO;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_mode  <= in_mode;
                s1_sum   <= core_sum;
                s1_exact <= core_exact;
            end
        end
    end

    // Stage 2: output registers, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= ERR_ZERO;
            out_exact <= ERR_ZERO;
            out_err   <= ERR_ZERO;
            out_viol  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum   <= s1_sum;
                out_exact <= s1_exact;
                out_err   <= err_next;
                out_viol  <= viol_next;
            end
        end
    end

    // Statistics: clear has priority over a concurrent output transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt <= {COUNT_W{1'b0}};
            max_err  <= ERR_ZERO;
        end else if (stat_clr) begin
            viol_cnt <= {COUNT_W{1'b0}};
            max_err  <= ERR_ZERO;
        end else if (out_xfer) begin
            if (out_viol && (viol_cnt != CNT_MAX)) begin
                viol_cnt <= viol_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            if (out_err > max_err) begin
                max_err <= out_err;
            end
        end
    end

endmodule : approx_adder_pipe

// File: tb/tb_approx_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_adder_pipe
// Scoreboard bench: expectations are pushed on every accepted input and
// popped by an output monitor. A main instance (K=2, COUNT_W=4) takes the
// directed scenarios and a random phase; one extra instance per K = 0..WIDTH
// runs an independent random regression.
// -----------------------------------------------------------------------------
module tb_approx_adder_pipe;

    localparam int W  = 4;
    localparam int ET = 4;

    typedef struct packed {
        logic [W:0] sum;
        logic [W:0] exact;
        logic [W:0] err;
        logic       viol;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: split operands arithmetically into high/low parts of 2^k
    function automatic exp_t model(input int a, input int b, input int mode, input int k);
        exp_t r;
        int p, ha, hb, la, lb, ex, ap, c, er;
        p  = 1 << k;
        ha = a / p;  hb = b / p;
        la = a % p;  lb = b % p;
        ex = a + b;
        c  = 0;
        if (k > 0) c = ((a >> (k - 1)) & (b >> (k - 1))) & 1;
        case (mode)
            0:       ap = ex;
            1:       ap = (ha + hb) * p;
            2:       ap = (ha + hb + c) * p + (la | lb);
            default: ap = (ha + hb) * p + (p - 1);
        endcase
        er      = (ex >= ap) ? ex - ap : ap - ex;
        r.sum   = (W+1)'(ap);
        r.exact = (W+1)'(ex);
        r.err   = (W+1)'(er);
        r.viol  = (er > ET);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main instance ----------------
    logic         rst;
    logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_viol, m_stat_clr;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   m_mode;
    logic [W:0]   m_out_sum, m_out_exact, m_out_err, m_max_err;
    logic [3:0]   m_viol_cnt;

    approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(2), .ET(ET), .COUNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .in_a      (m_a),
        .in_b      (m_b),
        .in_mode   (m_mode),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_sum   (m_out_sum),
        .out_exact (m_out_exact),
        .out_err   (m_out_err),
        .out_viol  (m_out_viol),
        .stat_clr  (m_stat_clr),
        .viol_cnt  (m_viol_cnt),
        .max_err   (m_max_err)
    );

    exp_t m_q[$];
    exp_t m_e;
    int   m_cnt   = 0;
    int   m_max   = 0;
    int   m_xfers = 0;

    // Main scoreboard: push on acceptance, pop/compare on output transfer, track stats
    always @(negedge clk) begin
        if (!rst) begin
            if (m_in_valid && m_in_ready) m_q.push_back(model(m_a, m_b, m_mode, 2));
            chk("m_viol_cnt", m_viol_cnt, m_cnt);
            chk("m_max_err", m_max_err, m_max);
            if (m_out_valid && m_out_ready) begin
                m_xfers++;
                if (m_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL m_spurious: output sum %0d with no item outstanding", m_out_sum);
                end else begin
                    m_e = m_q.pop_front();
                    chk("m_out_sum", m_out_sum, m_e.sum);
                    chk("m_out_exact", m_out_exact, m_e.exact);
                    chk("m_out_err", m_out_err, m_e.err);
                    chk("m_out_viol", m_out_viol, m_e.viol);
                    if (!m_stat_clr) begin
                        if (m_e.viol && m_cnt < 15) m_cnt++;
                        if (int'(m_e.err) > m_max) m_max = m_e.err;
                    end
                end
            end
            if (m_stat_clr) begin
                m_cnt = 0;
                m_max = 0;
            end
        end
    end

    task automatic send_one(input int a, input int b, input int mode,
                            input int e_sum, input int e_exact, input int e_err, input int e_viol);
        m_out_ready = 1'b1;
        m_a = a[W-1:0]; m_b = b[W-1:0]; m_mode = mode[1:0];
        m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
        chk("lat_s1_not_valid", m_out_valid, 0);
        step();
        chk("lat_s2_valid", m_out_valid, 1);
        chk("dir_sum", m_out_sum, e_sum);
        chk("dir_exact", m_out_exact, e_exact);
        chk("dir_err", m_out_err, e_err);
        chk("dir_viol", m_out_viol, e_viol);
        step();
    endtask

    // ---------------- per-K random lanes ----------------
    logic lane_rst;

    for (genvar k = 0; k <= W; k++) begin : g_lane
        logic         iv, ir, orr, sc, ov, vl;
        logic [W-1:0] a, b;
        logic [1:0]   md;
        logic [W:0]   os, oe, oerr, mx;
        logic [15:0]  vc;
        exp_t         q[$];
        exp_t         e;
        int           cnt  = 0;
        int           mxm  = 0;
        int           acc  = 0;
        bit           done = 1'b0;

        approx_adder_pipe #(.WIDTH(W), .APPROX_BITS(k), .ET(ET), .COUNT_W(16)) u_lane (
            .clk       (clk),
            .rst       (lane_rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (a),
            .in_b      (b),
            .in_mode   (md),
            .out_valid (ov),
            .out_ready (orr),
            .out_sum   (os),
            .out_exact (oe),
            .out_err   (oerr),
            .out_viol  (vl),
            .stat_clr  (sc),
            .viol_cnt  (vc),
            .max_err   (mx)
        );

        // Lane scoreboard
        always @(negedge clk) begin
            if (!lane_rst) begin
                if (iv && ir) begin
                    q.push_back(model(a, b, md, k));
                    acc++;
                end
                chk("lane_viol_cnt", vc, cnt);
                chk("lane_max_err", mx, mxm);
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL lane_spurious: K=%0d output sum %0d with no item outstanding", k, os);
                    end else begin
                        e = q.pop_front();
                        chk("lane_sum", os, e.sum);
                        chk("lane_exact", oe, e.exact);
                        chk("lane_err", oerr, e.err);
                        chk("lane_viol", vl, e.viol);
                        if (!sc) begin
                            if (e.viol && cnt < 65535) cnt++;
                            if (int'(e.err) > mxm) mxm = e.err;
                        end
                    end
                end
                if (sc) begin
                    cnt = 0;
                    mxm = 0;
                end
            end
        end

        // Lane stimulus: random valid, operands, mode, backpressure and rare clears
        initial begin
            iv = 1'b0; orr = 1'b0; sc = 1'b0; a = '0; b = '0; md = 2'd0;
            wait (lane_rst == 1'b0);
            for (int cyc = 0; cyc < 20000 && acc < 2000; cyc++) begin
                iv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
                sc  = ($urandom_range(0, 63) == 0);
                a   = W'($urandom);
                b   = W'($urandom);
                md  = 2'($urandom);
                step();
            end
            iv = 1'b0; sc = 1'b0; orr = 1'b1;
            chk("lane_accept_budget", (acc >= 2000), 1);
            for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) step();
            chk("lane_drain", q.size(), 0);
            done = 1'b1;
        end
    end

    // Watchdog
    initial begin
        #800000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    // Main directed sequence
    initial begin
        int acc, idx, base, accepted;
        rst = 1'b1; lane_rst = 1'b1;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_stat_clr = 1'b0;
        m_a = '0; m_b = '0; m_mode = 2'd0;
        step();
        step();
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_out_sum", m_out_sum, 0);
        chk("rst_out_exact", m_out_exact, 0);
        chk("rst_out_err", m_out_err, 0);
        chk("rst_out_viol", m_out_viol, 0);
        chk("rst_viol_cnt", m_viol_cnt, 0);
        chk("rst_max_err", m_max_err, 0);
        rst = 1'b0; lane_rst = 1'b0;
        chk("post_rst_in_ready", m_in_ready, 1);

        // Mode examples at a=3, b=3
        send_one(3, 3, 1, 0, 6, 6, 1);
        chk("trunc_viol_cnt", m_viol_cnt, 1);
        chk("trunc_max_err", m_max_err, 6);
        send_one(3, 3, 2, 7, 6, 1, 0);
        send_one(3, 3, 3, 3, 6, 3, 0);
        send_one(3, 3, 0, 6, 6, 0, 0);
        chk("modes_viol_cnt", m_viol_cnt, 1);

        // Reset with two items in flight
        m_out_ready = 1'b0;
        m_a = 4'd1; m_b = 4'd2; m_mode = 2'd0; m_in_valid = 1'b1;
        step();
        m_a = 4'd3; m_b = 4'd1; m_mode = 2'd1;
        step();
        m_in_valid = 1'b0;
        chk("inflight_out_valid", m_out_valid, 1);
        chk("inflight_in_ready", m_in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", m_out_valid, 0);
        chk("async_rst_viol_cnt", m_viol_cnt, 0);
        chk("async_rst_max_err", m_max_err, 0);
        chk("async_rst_out_sum", m_out_sum, 0);
        m_q.delete();
        m_cnt = 0; m_max = 0;
        m_out_ready = 1'b1;
        step();
        step();
        chk("in_rst_out_valid", m_out_valid, 0);
        rst = 1'b0;
        chk("rst_release_in_ready", m_in_ready, 1);
        send_one(2, 2, 0, 4, 4, 0, 0);

        // Backpressure: out_ready low for 4 cycles with continuous offers
        m_out_ready = 1'b0;
        base = m_xfers;
        acc = 0; idx = 0;
        for (int i = 0; i < 4; i++) begin
            m_in_valid = 1'b1;
            m_a = W'(idx + 1); m_b = W'(idx); m_mode = 2'd0;
            accepted = m_in_ready;
            step();
            if (accepted) begin
                acc++;
                idx++;
            end
            if (i >= 1) begin
                chk("bp_hold_valid", m_out_valid, 1);
                chk("bp_hold_sum", m_out_sum, 1);
                chk("bp_hold_exact", m_out_exact, 1);
            end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", m_in_ready, 0);
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        step(); step(); step();
        chk("bp_xfers", m_xfers - base, 2);
        chk("bp_queue_empty", m_q.size(), 0);

        // Saturation of the 4-bit violation counter
        acc = 0;
        m_a = 4'd3; m_b = 4'd3; m_mode = 2'd1; m_in_valid = 1'b1; m_out_ready = 1'b1;
        for (int i = 0; i < 100 && acc < 20; i++) begin
            accepted = m_in_ready;
            step();
            if (accepted) acc++;
        end
        m_in_valid = 1'b0;
        step(); step(); step();
        chk("sat_viol_cnt", m_viol_cnt, 15);
        chk("sat_max_err", m_max_err, 6);

        // Clear coinciding with a violating transfer
        m_in_valid = 1'b1;
        step();
        m_in_valid = 1'b0;
        step();
        chk("clr_item_valid", m_out_valid, 1);
        chk("clr_item_viol", m_out_viol, 1);
        m_stat_clr = 1'b1;
        step();
        m_stat_clr = 1'b0;
        chk("clr_viol_cnt", m_viol_cnt, 0);
        chk("clr_max_err", m_max_err, 0);

        // Random phase on the main instance
        for (int i = 0; i < 1500; i++) begin
            m_in_valid  = ($urandom_range(0, 3) != 0);
            m_out_ready = ($urandom_range(0, 2) != 0);
            m_stat_clr  = ($urandom_range(0, 49) == 0);
            m_a = W'($urandom); m_b = W'($urandom); m_mode = 2'($urandom);
            step();
        end
        m_in_valid = 1'b0; m_stat_clr = 1'b0; m_out_ready = 1'b1;
        for (int i = 0; i < 20 && m_q.size() != 0; i++) step();
        chk("main_drain", m_q.size(), 0);

        // Wait for the lanes
        for (int i = 0; i < 30000 &&
             !(g_lane[0].done && g_lane[1].done && g_lane[2].done &&
               g_lane[3].done && g_lane[4].done); i++) begin
            step();
        end
        chk("lanes_done", (g_lane[0].done && g_lane[1].done && g_lane[2].done &&
                           g_lane[3].done && g_lane[4].done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_approx_adder_pipe
